reg_share_arbiter: RTL and testbench

Shares a single DATA_W-bit storage register between N_REQ write requesters.
- Arbitration is round-robin, with a req/gnt/ack handshake per requester.
- The block owns the register: data_out is the register value, and it changes only on a committed write.
- It sits between several producer blocks and any consumer that reads the shared register value.

---
 rtl/reg_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/reg_share_arbiter.sv | 115 +++++++++++
 tb/tb_reg_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the shared-register write arbiter: state encoding and
// default sizing.
package reg_arb_pkg;

  localparam int unsigned N_REQ_DEFAULT  = 4;
  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT,
    StAck   = ST_ACK
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping from N_REQ-1 back to 0 (N_REQ need not be a power of two).
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // One extra bit so ptr + k (at most 2*N_REQ-2) never overflows before the wrap.
  logic [IDX_W:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(N_REQ)) begin
        idx = idx - (IDX_W + 1)'(N_REQ);
      end
      if (!any_req && req[idx[IDX_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Single shared register written by N_REQ requesters through a round-robin
// req/gnt/ack handshake; one committed write per three cycles at most.
module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       data_out,
  output logic [IDX_W-1:0]        owner,
  output logic                    busy,
  output logic [7:0]              wr_count
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [7:0]            wr_count_q, wr_count_d;

  logic [IDX_W-1:0]      pick_winner;
  logic                  pick_any;
  logic [DATA_W-1:0]     words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = wdata[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    hold_d     = hold_q;
    data_d     = data_q;
    ack_d      = '0;
    wr_count_d = wr_count_q;
    gnt        = '0;
    case (state_q)
      StGrant: begin
        gnt[sel_q] = 1'b1;
        if (req[sel_q]) begin
          data_d       = hold_q;
          owner_d      = sel_q;
          ack_d[sel_q] = 1'b1;
          wr_count_d   = wr_count_q + 8'd1;
          rr_ptr_d     = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
          state_d      = StAck;
        end else begin
          // Aborted: requester keeps its priority slot.
          state_d = StIdle;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        if (pick_any) begin
          sel_d   = pick_winner;
          hold_d  = words[pick_winner];
          state_d = StGrant;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign ack      = ack_q;
  assign data_out = data_q;
  assign owner    = owner_q;
  assign wr_count = wr_count_q;
  assign busy     = (state_q == StGrant) || (state_q == StAck);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_reg_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   data_out;
  logic [1:0]     owner;
  logic           busy;
  logic [7:0]     wr_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit auto_drop = 1'b0;

  always #5 clk = ~clk;

  reg_share_arbiter #(
    .N_REQ  (N),
    .DATA_W (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .ack      (ack),
    .data_out (data_out),
    .owner    (owner),
    .busy     (busy),
    .wr_count (wr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_phase counts cycles into an in-flight write
  // (0 none, 1 granted, 2 committed).
  int         m_phase, m_sel, m_ptr, m_owner, m_count;
  logic [7:0] m_hold, m_data;
  logic [N-1:0] m_ack;
  int         log_owner[$];
  int         log_data[$];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_sel = 0; m_ptr = 0; m_owner = 0; m_count = 0;
      m_hold = 8'h00; m_data = 8'h00; m_ack = '0;
    end else begin
      m_ack = '0;
      case (m_phase)
        1: begin
          if (req[m_sel]) begin
            m_data = m_hold;
            m_owner = m_sel;
            m_count = (m_count + 1) % 256;
            m_ptr = (m_sel + 1) % N;
            m_ack[m_sel] = 1'b1;
            log_owner.push_back(m_sel);
            log_data.push_back(int'(m_hold));
            m_phase = 2;
          end else begin
            m_phase = 0;
          end
        end
        2: m_phase = 0;
        default: begin
          if (req != '0) begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
              if (!found && req[(m_ptr + k) % N]) begin
                found = 1'b1;
                m_sel = (m_ptr + k) % N;
              end
            end
            m_hold = wdata[m_sel*W +: W];
            m_phase = 1;
          end
        end
      endcase
    end
  end

  logic [N-1:0] e_gnt;
  always @(negedge clk) begin
    if (chk_en) begin
      e_gnt = '0;
      if (m_phase == 1) e_gnt[m_sel] = 1'b1;
      check("model_gnt", gnt, e_gnt);
      check("model_ack", ack, m_ack);
      check("model_data", data_out, m_data);
      check("model_owner", owner, m_owner);
      check("model_busy", busy, m_phase != 0);
      check("model_wr_count", wr_count, m_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~m_ack;
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    log_owner.delete();
    log_data.delete();
  endtask

  task automatic run_until_idle(input string name);
    int n;
    n = 0;
    while ((req != '0 || m_phase != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for idle, req=0x%0h", name, req);
    end
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (m_ack == '0 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for ack", name);
    end
  endtask

  initial begin
    int cyc;
    int ack_t[$];
    int ack_who[$];

    rst = 1'b1;
    req = '0;
    wdata = '0;

    // Reset and idle
    do_reset();
    chk_en = 1'b1;
    repeat (5) tick();
    check("idle_data", data_out, 8'h00);
    check("idle_owner", owner, 0);
    check("idle_busy", busy, 0);
    check("idle_gnt", gnt, 0);
    check("idle_ack", ack, 0);
    check("idle_wr_count", wr_count, 0);

    // Single request from requester 2
    do_reset();
    auto_drop = 1'b1;
    set_word(2, 8'hA5);
    req = 4'b0100;
    tick();
    check("single_gnt", gnt, 4'b0100);
    set_word(2, 8'hFF);
    tick();
    check("single_ack", ack, 4'b0100);
    check("single_data", data_out, 8'hA5);
    check("single_owner", owner, 2);
    check("single_wr_count", wr_count, 1);
    tick();
    check("single_busy_n3", busy, 0);
    run_until_idle("single");

    // Four requesters contending
    do_reset();
    set_word(0, 8'h11);
    set_word(1, 8'h22);
    set_word(2, 8'h33);
    set_word(3, 8'h44);
    req = 4'b1111;
    cyc = 0;
    while ((req != '0 || m_phase != 0) && cyc < 60) begin
      tick();
      cyc++;
      if (ack != '0) begin
        ack_t.push_back(cyc);
        for (int i = 0; i < N; i++) if (ack[i]) ack_who.push_back(i);
      end
    end
    check("rr_ack_count", ack_t.size(), 4);
    check("rr_log_size", log_owner.size(), 4);
    if (log_owner.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("rr_model_owner", log_owner[i], i);
        check("rr_model_data", log_data[i], 32'h11 * (i + 1));
      end
    end
    if (ack_t.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_dut_ack_order", ack_who[i], i);
      for (int i = 1; i < 4; i++) check("rr_ack_spacing", ack_t[i] - ack_t[i-1], 3);
    end
    check("rr_wr_count", wr_count, 4);
    check("rr_data", data_out, 8'h44);
    check("rr_owner", owner, 3);

    // Abort during GRANT keeps the pointer
    do_reset();
    set_word(1, 8'h77);
    req = 4'b0010;
    tick();
    check("abort_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    check("abort_data", data_out, 8'h00);
    check("abort_wr_count", wr_count, 0);
    set_word(0, 8'h10);
    set_word(1, 8'h21);
    req = 4'b0011;
    tick();
    check("abort_ptr_kept_gnt", gnt, 4'b0001);
    run_until_idle("abort");
    check("abort_log_size", log_owner.size(), 2);
    if (log_owner.size() == 2) begin
      check("abort_first", log_owner[0], 0);
      check("abort_second", log_owner[1], 1);
    end
    check("abort_final_data", data_out, 8'h21);
    check("abort_final_count", wr_count, 2);

    // Reset while a write is granted
    do_reset();
    set_word(0, 8'h99);
    req = 4'b0001;
    run_until_idle("pre_reset_commit");
    check("pre_reset_data", data_out, 8'h99);
    set_word(3, 8'h5A);
    req = 4'b1000;
    tick();
    check("rstg_gnt", gnt, 4'b1000);
    rst = 1'b1;
    tick();
    check("rstg_busy", busy, 0);
    check("rstg_data", data_out, 8'h00);
    check("rstg_ack", ack, 0);
    rst = 1'b0;
    req = '0;
    repeat (4) begin
      tick();
      check("rstg_no_ack", ack, 0);
    end
    check("rstg_wr_count", wr_count, 0);

    // wr_count wraps after 256 commits
    do_reset();
    for (int i = 0; i < 256; i++) begin
      set_word(1, 8'(i) ^ 8'h3C);
      req = 4'b0010;
      wait_ack("wrap");
      tick();
    end
    check("wrap_wr_count", wr_count, 8'h00);
    check("wrap_data", data_out, 8'hC3);
    check("wrap_owner", owner, 1);
    check("wrap_log_size", log_owner.size(), 256);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
